// File: rtl/obstacle_scroller.sv
// Multi-slot obstacle scroller: per frame tick, erase/move/draw each live slot, then maybe spawn one.
// Outputs are registered; a request holds x/y/erase until draw_ack, and ticks that arrive during a busy pass are queued one deep.
module obstacle_scroller #(
    parameter int         CHANNELS  = 4,
    parameter int         X_W       = 8,
    parameter int         Y_W       = 6,
    parameter int         X_START   = 159,
    parameter int         Y_MAX     = 52,
    parameter int         SPEED     = 1,
    parameter int         TICK_DIV  = 833333,
    parameter int         SPAWN_GAP = 40,
    parameter logic [9:0] LFSR_SEED = 10'h094
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                draw_ack,
    output logic                draw_req,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic                erase,
    output logic [CHANNELS-1:0] active,
    output logic                frame_done,
    output logic                overrun
);
    localparam int DIV_W = $clog2(TICK_DIV + 1);
    localparam int GAP_W = $clog2(SPAWN_GAP + 1);
    localparam int IDX_W = $clog2(CHANNELS + 1);
    localparam int SL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(SPAWN_GAP);
    localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(CHANNELS);
    localparam logic [X_W-1:0]   X_START_V  = X_W'(X_START);
    localparam logic [X_W-1:0]   SPEED_V    = X_W'(SPEED);
    localparam logic [Y_W-1:0]   Y_MAX_V    = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0]   Y_WRAP_V   = Y_W'(Y_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_ERASE, S_MOVE, S_DRAW, S_SPAWN, S_SDRAW, S_DONE
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [DIV_W-1:0]    r_div;
    logic                r_tick;
    logic                r_pend;
    logic                r_ovr;
    logic [GAP_W-1:0]    r_gap;
    logic [9:0]          r_lfsr;
    logic [X_W-1:0]      r_sx [CHANNELS];
    logic [Y_W-1:0]      r_sy [CHANNELS];
    logic [CHANNELS-1:0] r_act;
    logic                r_req;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic                r_erase;
    logic                r_fdone;

    logic [SL_W-1:0]     w_slot;
    logic                w_ack;
    logic                w_clr_pend;
    logic                w_spawn;
    logic                w_free_any;
    logic [SL_W-1:0]     w_free_slot;
    logic [Y_W-1:0]      w_ly;
    logic [Y_W-1:0]      w_sy;
    logic [X_W-1:0]      w_nx;

    assign w_slot     = r_idx[SL_W-1:0];
    assign w_ack      = draw_ack & r_req;
    assign w_clr_pend = (r_state == S_IDLE) && r_pend;
    assign w_ly       = r_lfsr[Y_W-1:0];
    // Out-of-range rows fold back into 0..Y_MAX instead of being clipped.
    assign w_sy       = (w_ly <= Y_MAX_V) ? w_ly : w_ly - Y_WRAP_V;
    assign w_nx       = r_sx[w_slot] - SPEED_V;
    assign w_spawn    = (r_state == S_SPAWN) && (r_gap == GAP_MAX) && w_free_any;

    always_comb begin
        w_free_any  = 1'b0;
        w_free_slot = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (!r_act[i]) begin
                w_free_any  = 1'b1;
                w_free_slot = SL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= DIV_RELOAD;
            r_tick <= 1'b0;
            r_lfsr <= LFSR_SEED;
        end else begin
            r_tick <= 1'b0;
            if (enable) begin
                r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
                if (r_div == '0) begin
                    r_div  <= DIV_RELOAD;
                    r_tick <= 1'b1;
                end else begin
                    r_div <= r_div - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
            r_gap   <= GAP_MAX;
            r_act   <= '0;
            r_req   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_erase <= 1'b0;
            r_fdone <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
            end
        end else begin
            // One-deep tick queue; a second tick while one is still queued is dropped.
            r_pend <= r_tick | (r_pend & ~w_clr_pend);
            if (r_tick && r_pend && !w_clr_pend)
                r_ovr <= 1'b1;
            if (w_spawn)
                r_gap <= '0;
            else if (r_tick && (r_gap != GAP_MAX))
                r_gap <= r_gap + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (r_pend) begin
                        r_idx   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_idx == IDX_END) begin
                        r_state <= S_SPAWN;
                    end else if (r_act[w_slot]) begin
                        r_req   <= 1'b1;
                        r_erase <= 1'b1;
                        r_x     <= r_sx[w_slot];
                        r_y     <= r_sy[w_slot];
                        r_state <= S_ERASE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_ERASE: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_state <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (r_sx[w_slot] <= SPEED_V) begin
                        r_act[w_slot] <= 1'b0;
                        r_idx         <= r_idx + 1'b1;
                        r_state       <= S_SCAN;
                    end else begin
                        r_sx[w_slot] <= w_nx;
                        r_x          <= w_nx;
                        r_erase      <= 1'b0;
                        r_req        <= 1'b1;
                        r_state      <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SPAWN: begin
                    if (w_spawn) begin
                        r_act[w_free_slot] <= 1'b1;
                        r_sx[w_free_slot]  <= X_START_V;
                        r_sy[w_free_slot]  <= w_sy;
                        r_x                <= X_START_V;
                        r_y                <= w_sy;
                        r_erase            <= 1'b0;
                        r_req              <= 1'b1;
                        r_state            <= S_SDRAW;
                    end else begin
                        r_fdone <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_SDRAW: begin
                    if (w_ack) begin
                        r_req   <= 1'b0;
                        r_fdone <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_fdone <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign draw_req   = r_req;
    assign x          = r_x;
    assign y          = r_y;
    assign erase      = r_erase;
    assign active     = r_act;
    assign frame_done = r_fdone;
    assign overrun    = r_ovr;
endmodule

// File: tb/tb_obstacle_scroller.sv
// Randomized bench: transaction-level obstacle model with a reactive drawer that returns acks after random delays.
module tb_obstacle_scroller;
    localparam int         CH   = 4;
    localparam int         XS   = 159;
    localparam int         YM   = 52;
    localparam int         SPD  = 3;
    localparam int         TD   = 64;
    localparam int         GAP  = 3;
    localparam logic [9:0] SEED = 10'h094;

    logic          clk = 1'b0;
    logic          reset, enable, draw_ack;
    logic          draw_req, erase, frame_done, overrun;
    logic [7:0]    x;
    logic [5:0]    y;
    logic [CH-1:0] active;

    obstacle_scroller #(
        .CHANNELS(CH), .X_W(8), .Y_W(6), .X_START(XS), .Y_MAX(YM), .SPEED(SPD),
        .TICK_DIV(TD), .SPAWN_GAP(GAP), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .draw_ack(draw_ack),
        .draw_req(draw_req), .x(x), .y(y), .erase(erase), .active(active),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference LFSR: one step per enabled clock, restarted from the seed by reset.
    int         cyc = 0;
    logic [9:0] m_lfsr = SEED;
    logic [9:0] m_lfsr_prev = SEED;
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        m_lfsr_prev <= m_lfsr;
        if (reset)
            m_lfsr <= SEED;
        else if (enable)
            m_lfsr <= 10'((int'(m_lfsr) * 2) % 1024 + ((int'(m_lfsr) / 512) ^ ((int'(m_lfsr) / 64) % 2)));
    end

    function automatic int map_row(input logic [9:0] l);
        int v;
        v = int'(l) % 64;
        return (v <= YM) ? v : v - (YM + 1);
    endfunction

    typedef struct {
        int kind;  // 0 erase, 1 draw, 2 spawn
        int slot;
        int px;
        int py;
    } exp_t;

    exp_t q[$];
    int   m_x[CH];
    int   m_y[CH];
    bit   m_act[CH];
    int   m_cnt;
    bit   model_on = 1'b0;

    function automatic int act_mask();
        int m;
        m = 0;
        for (int i = 0; i < CH; i++)
            if (m_act[i]) m += (1 << i);
        return m;
    endfunction

    task automatic gen_pass();
        int j;
        m_cnt = (m_cnt + 1 > GAP) ? GAP : m_cnt + 1;
        for (int i = 0; i < CH; i++) begin
            if (m_act[i]) begin
                q.push_back('{0, i, m_x[i], m_y[i]});
                if (m_x[i] <= SPD) begin
                    m_act[i] = 1'b0;
                end else begin
                    m_x[i] -= SPD;
                    q.push_back('{1, i, m_x[i], m_y[i]});
                end
            end
        end
        if (m_cnt == GAP) begin
            j = -1;
            for (int i = CH - 1; i >= 0; i--)
                if (!m_act[i]) j = i;
            if (j >= 0) begin
                m_act[j] = 1'b1;
                m_x[j]   = XS;
                q.push_back('{2, j, XS, 0});
                m_cnt = 0;
            end
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < CH; i++) begin
            m_act[i] = 1'b0;
            m_x[i]   = 0;
            m_y[i]   = 0;
        end
        m_cnt = GAP;
        q.delete();
        gen_pass();
    endtask

    // Drawer state
    bit         prev_req = 1'b0, just_acc = 1'b0, prev_fd = 1'b0;
    bit         stall_req = 1'b0, stalling = 1'b0, stall_done = 1'b0;
    int         stall_len = 0, wait_n = 0;
    int         fd_cnt = 0, fd_at_stall = 0;
    int         rise_cyc = 0, last_ack_cyc = 0;
    logic [9:0] rise_lfsr;
    logic [7:0] hx;
    logic [5:0] hy;
    logic       he;

    task automatic on_frame_done();
        fd_cnt++;
        check_eq("fd_pulse_width", int'(prev_fd), 0);
        if (model_on) begin
            check_eq("pass_all_reqs_seen", q.size(), 0);
            check_eq("active_mask", int'(active), act_mask());
            check_eq("overrun_clear", int'(overrun), 0);
            q.delete();
            gen_pass();
        end
    endtask

    task automatic on_accept();
        exp_t e;
        int   ey;
        if (stalling) begin
            check_eq("overrun_after_stall", int'(overrun), 1);
            stall_done  = 1'b1;
            fd_at_stall = fd_cnt;
            stalling    = 1'b0;
        end
        if (model_on) begin
            check_eq("req_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check_eq("req_erase_flag", int'(he), int'(e.kind == 0));
                check_eq("req_x", int'(hx), e.px);
                if (e.kind == 2) begin
                    ey = map_row(rise_lfsr);
                    m_y[e.slot] = ey;
                    check_eq("spawn_y", int'(hy), ey);
                    check_eq("spawn_y_legal", int'(int'(hy) <= YM), 1);
                end else begin
                    check_eq("req_y", int'(hy), e.py);
                end
                if (e.kind == 1)
                    check_eq("erase_ack_to_draw_req", rise_cyc - last_ack_cyc, 2);
            end
        end
        last_ack_cyc = cyc;
    endtask

    initial begin
        draw_ack = 1'b0;
        forever begin
            @(negedge clk);
            draw_ack = 1'b0;
            if (reset) begin
                prev_req = 1'b0;
                just_acc = 1'b0;
                prev_fd  = 1'b0;
                wait_n   = 0;
                stalling = 1'b0;
                continue;
            end
            if (frame_done) on_frame_done();
            prev_fd = frame_done;
            if (just_acc) check_eq("req_low_after_ack", int'(draw_req), 0);
            just_acc = 1'b0;
            if (draw_req) begin
                if (!prev_req) begin
                    hx        = x;
                    hy        = y;
                    he        = erase;
                    rise_cyc  = cyc;
                    rise_lfsr = m_lfsr_prev;
                    if (stall_req) begin
                        wait_n    = stall_len;
                        stall_req = 1'b0;
                        stalling  = 1'b1;
                    end else begin
                        wait_n = $urandom_range(0, 3);
                    end
                end else begin
                    check_eq("req_fields_stable", int'({x, y, erase}), int'({hx, hy, he}));
                end
                if (wait_n == 0) begin
                    draw_ack = 1'b1;
                    just_acc = 1'b1;
                    on_accept();
                end else begin
                    wait_n--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                draw_ack = 1'b1;
            end
            prev_req = draw_req;
        end
    end

    task automatic run_rand(input int n);
        int hold;
        hold = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (hold > 0) begin
                hold--;
                enable = 1'b0;
            end else begin
                enable = 1'b1;
                if ($urandom_range(0, 59) == 0) hold = $urandom_range(1, 15);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_draw_req"}, int'(draw_req), 0);
        check_eq({tag, "_x"}, int'(x), 0);
        check_eq({tag, "_y"}, int'(y), 0);
        check_eq({tag, "_erase"}, int'(erase), 0);
        check_eq({tag, "_active"}, int'(active), 0);
        check_eq({tag, "_frame_done"}, int'(frame_done), 0);
        check_eq({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        int fd0;
        reset  = 1'b1;
        enable = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        model_init();
        model_on = 1'b1;
        reset    = 1'b0;

        run_rand(9000);
        check_eq("passes_in_random_run", int'(fd_cnt >= 100), 1);

        // Stall a request across two ticks, then stop ticks and count the remaining passes.
        @(negedge clk);
        enable    = 1'b1;
        model_on  = 1'b0;
        stall_len = 2 * TD + 2;
        stall_req = 1'b1;
        for (int i = 0; i < 600 && !stall_done; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("stall_released", int'(stall_done), 1);
        enable = 1'b0;
        repeat (400) @(negedge clk);
        check_eq("passes_after_stall", fd_cnt - fd_at_stall, 2);

        // Reset while a request is outstanding.
        enable    = 1'b1;
        stall_len = 100000;
        stall_req = 1'b1;
        for (int i = 0; i < 400 && !stalling; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("req_before_reset", int'(stalling && draw_req), 1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreq_rst");
        repeat (3) @(negedge clk);
        stall_req = 1'b0;
        model_init();
        model_on = 1'b1;
        reset    = 1'b0;
        fd0      = fd_cnt;
        run_rand(3000);
        check_eq("passes_after_reset", int'(fd_cnt - fd0 >= 30), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
